// File: rtl/bp_clint_responder.sv
// Single-hart CLINT slave: mipi / mtimecmp / mtime registers, plic stub, timer and software irqs.
// One outstanding request, response registered one cycle after accept. Define BP_CLINT_RTC_DIV_EN for the mtime prescaler.
module bp_clint_responder #(
    parameter int paddr_width_p = 40,
    parameter int dword_width_p = 64,
    parameter int rtc_div_p     = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     req_v_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [paddr_width_p-1:0] req_addr_i,
    input  logic [1:0]               req_size_i,
    input  logic [dword_width_p-1:0] req_data_i,
    output logic                     resp_v_o,
    output logic [dword_width_p-1:0] resp_data_o,
    input  logic                     resp_yumi_i,
    output logic                     timer_irq_o,
    output logic                     software_irq_o
);

    typedef enum logic {
        e_ready,
        e_resp
    } state_e;

    state_e state_q, state_d;

    logic [dword_width_p-1:0] mtime_q, mtime_d;
    logic [dword_width_p-1:0] mtimecmp_q, mtimecmp_d;
    logic [dword_width_p-1:0] resp_data_q, resp_data_d;
    logic                     mipi_q, mipi_d;
    logic                     timer_irq_q, timer_irq_d;

    if (rtc_div_p < 1) begin : g_bad_rtc_div
        $error("rtc_div_p must be >= 1");
    end

    logic        hit;
    logic [16:0] reg_sel;
    logic        sel_mipi, sel_mtimecmp, sel_mtime;
    logic [2:0]  off;
    logic [5:0]  shamt;
    logic [7:0]  base_mask, byte_mask;
    logic [dword_width_p-1:0] bit_mask, cur_reg, wr_val, rd_val;
    logic        accept, store, mtime_wr, tick;

    assign hit          = (req_addr_i[paddr_width_p-1:20] == (paddr_width_p-20)'(3));
    assign reg_sel      = req_addr_i[19:3];
    assign sel_mipi     = hit && (reg_sel == 17'h0000);
    assign sel_mtimecmp = hit && (reg_sel == 17'h0800);
    assign sel_mtime    = hit && (reg_sel == 17'h17ff);
    assign off          = req_addr_i[2:0];
    assign shamt        = {off, 3'b000};

    assign accept   = req_v_i && (state_q == e_ready);
    assign store    = accept && req_we_i;
    assign mtime_wr = store && sel_mtime;

    // Byte lanes shifted past byte 7 fall off the 8-bit mask (misaligned overflow dropped).
    always_comb begin
        base_mask = 8'h00;
        case (req_size_i)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0f;
            default: base_mask = 8'hff;
        endcase
        byte_mask = base_mask << off;
        bit_mask  = '0;
        for (int b = 0; b < 8; b++) begin
            bit_mask[8*b +: 8] = {8{byte_mask[b]}};
        end
    end

    // The plic stub and misses read as zero; mipi exposes only bit 0.
    always_comb begin
        cur_reg = '0;
        if (sel_mipi)          cur_reg = {{(dword_width_p-1){1'b0}}, mipi_q};
        else if (sel_mtimecmp) cur_reg = mtimecmp_q;
        else if (sel_mtime)    cur_reg = mtime_q;
    end

    assign wr_val = (cur_reg & ~bit_mask) | ((req_data_i << shamt) & bit_mask);
    assign rd_val = (cur_reg & bit_mask) >> shamt;

`ifdef BP_CLINT_RTC_DIV_EN
    localparam int presc_w = (rtc_div_p > 1) ? $clog2(rtc_div_p) : 1;

    logic [presc_w-1:0] presc_q, presc_d;

    assign tick = (presc_q == presc_w'(rtc_div_p - 1));

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (tick || mtime_wr) presc_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) presc_q <= '0;
        else         presc_q <= presc_d;
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        mtime_d     = mtime_q;
        mtimecmp_d  = mtimecmp_q;
        mipi_d      = mipi_q;
        resp_data_d = resp_data_q;
        if (mtime_wr)  mtime_d = wr_val;
        else if (tick) mtime_d = mtime_q + 1'b1;
        if (store && sel_mtimecmp) mtimecmp_d = wr_val;
        if (store && sel_mipi)     mipi_d     = wr_val[0];
        if (accept)                resp_data_d = req_we_i ? '0 : rd_val;
        timer_irq_d = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= e_ready;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            mipi_q      <= 1'b0;
            resp_data_q <= '0;
            timer_irq_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            mipi_q      <= mipi_d;
            resp_data_q <= resp_data_d;
            timer_irq_q <= timer_irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            e_ready: if (req_v_i)     state_d = e_resp;
            e_resp:  if (resp_yumi_i) state_d = e_ready;
            default:                  state_d = e_ready;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == e_ready);
        resp_v_o    = (state_q == e_resp);
    end

    assign resp_data_o    = resp_data_q;
    assign timer_irq_o    = timer_irq_q;
    assign software_irq_o = mipi_q;

endmodule
